// File: rtl/comparator_sort_ctrl.sv
// comparator_sort_ctrl
//   Sorts a block of DEPTH unsigned WIDTH-bit words into ascending order. It
//   uses one strict greater-than comparator: a bubble sort runs one
//   compare/swap per clock.
//   Ports:
//     clk, rst             rising-edge clock, synchronous active-high reset
//     in_valid/in_ready    load handshake, in_data is the word to load
//     out_valid/out_ready  drain handshake, out_data is the sorted word,
//                          out_last marks the largest (final) word
//     busy                 high while sorting or draining
//     swap_count           swaps performed on the current block
module comparator_sort_ctrl #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [4:0]       swap_count
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_J   = PTR_W'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] j_q, j_d;
  logic [PTR_W-1:0] pass_q, pass_d;
  logic             swapped_q, swapped_d;
  logic [4:0]       swap_count_q, swap_count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [PTR_W-1:0] j_nxt;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             gt;

  // Shared comparator: strict so equal words never swap (stable sort).
  assign j_nxt = j_q + PTR_W'(1);
  assign cmp_a = mem_q[j_q];
  assign cmp_b = mem_q[j_nxt];
  assign gt    = cmp_a > cmp_b;

  // Handshake and status outputs depend only on registered state.
  assign in_ready   = (state_q == ST_LOAD);
  assign out_valid  = (state_q == ST_DRAIN);
  assign busy       = (state_q != ST_LOAD);
  assign out_data   = mem_q[rd_ptr_q];
  assign out_last   = (state_q == ST_DRAIN) && (rd_ptr_q == LAST_IDX);
  assign swap_count = swap_count_q;

  // Next-state, pointer and storage update.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    j_d          = j_q;
    pass_d       = pass_q;
    swapped_d    = swapped_q;
    swap_count_d = swap_count_q;
    mem_d        = mem_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[wr_ptr_q] = in_data;
          if (wr_ptr_q == '0) begin
            swap_count_d = 5'd0;
          end
          if (wr_ptr_q == LAST_IDX) begin
            state_d   = ST_SORT;
            wr_ptr_d  = '0;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end

      ST_SORT: begin
        if (gt) begin
          mem_d[j_q]   = cmp_b;
          mem_d[j_nxt] = cmp_a;
          swap_count_d = swap_count_q + 5'd1;
          swapped_d    = 1'b1;
        end
        if (j_q == LAST_J) begin
          // End of pass: run another only if something moved and passes remain.
          if ((swapped_q || gt) && (pass_q < LAST_J)) begin
            j_d       = '0;
            pass_d    = pass_q + PTR_W'(1);
            swapped_d = 1'b0;
          end else begin
            state_d  = ST_DRAIN;
            rd_ptr_d = '0;
          end
        end else begin
          j_d = j_nxt;
        end
      end

      ST_DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_q == LAST_IDX) begin
            state_d  = ST_LOAD;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      j_q          <= '0;
      pass_q       <= '0;
      swapped_q    <= 1'b0;
      swap_count_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      j_q          <= j_d;
      pass_q       <= pass_d;
      swapped_q    <= swapped_d;
      swap_count_q <= swap_count_d;
    end
  end

  // Block storage carries no reset; contents are rewritten on every load.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// Directed bench for comparator_sort_ctrl (WIDTH=3, DEPTH=4).
module tb_comparator_sort_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_last;
  logic       busy;
  logic [4:0] swap_count;

  int errors;
  int checks;

  comparator_sort_ctrl #(.WIDTH(3), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .swap_count (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_last !== 1'b0 || swap_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_last=%b swap_count=%0d, want 1 0 0 0 0",
               in_ready, out_valid, busy, out_last, swap_count);
    end
  endtask

  // Loads four words; leaves in_valid at hold_valid afterwards.
  task automatic load_block(input logic [0:3][2:0] w, input logic hold_valid);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready[%0d]: in_ready=%b, want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = w[i];
      step();
    end
    in_valid = hold_valid;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_done: in_ready=%b busy=%b out_valid=%b, want 0 1 0",
               in_ready, busy, out_valid);
    end
  endtask

  // Counts SORT cycles until out_valid rises; optionally toggles in_valid.
  task automatic wait_sort(input int exp_cycles, input logic pulse);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL sort_ctrl[%0d]: in_ready=%b busy=%b, want 0 1", cnt, in_ready, busy);
      end
      if (pulse) in_valid = ~in_valid;
      in_data = 3'd0;
      step();
      cnt++;
    end
    checks++;
    if (cnt !== exp_cycles) begin
      errors++;
      $display("FAIL sort_cycles: got %0d, want %0d", cnt, exp_cycles);
    end
  endtask

  task automatic drain_block(input logic [0:3][2:0] w, input logic stall,
                             input logic pulse, input logic [4:0] exp_swaps);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i] || out_last !== (i == 3) ||
          swap_count !== exp_swaps) begin
        errors++;
        $display("FAIL drain_word[%0d]: valid=%b data=%0d last=%b swaps=%0d, want 1 %0d %b %0d",
                 i, out_valid, out_data, out_last, swap_count, w[i], (i == 3), exp_swaps);
      end
      if (i == 0 && stall) begin
        for (int k = 0; k < 3; k++) begin
          out_ready = 1'b0;
          if (pulse) in_valid = ~in_valid;
          step();
          checks++;
          if (out_valid !== 1'b1 || out_data !== w[0] || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: valid=%b data=%0d last=%b in_ready=%b, want 1 %0d 0 0",
                     k, out_valid, out_data, out_last, in_ready, w[0]);
          end
        end
      end
      out_ready = 1'b1;
      if (i == 3) in_valid = 1'b0;
      else if (pulse) in_valid = ~in_valid;
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || swap_count !== exp_swaps) begin
      errors++;
      $display("FAIL drain_done: busy=%b in_ready=%b out_valid=%b swaps=%0d, want 0 1 0 %0d",
               busy, in_ready, out_valid, swap_count, exp_swaps);
    end
  endtask

  task automatic test_basic();
    load_block({3'd5, 3'd3, 3'd7, 3'd1}, 1'b1);
    wait_sort(9, 1'b0);
    drain_block({3'd1, 3'd3, 3'd5, 3'd7}, 1'b0, 1'b0, 5'd4);
  endtask

  task automatic test_backpressure();
    load_block({3'd5, 3'd3, 3'd7, 3'd1}, 1'b0);
    wait_sort(9, 1'b1);
    drain_block({3'd1, 3'd3, 3'd5, 3'd7}, 1'b1, 1'b1, 5'd4);
  endtask

  task automatic test_sorted();
    load_block({3'd0, 3'd2, 3'd4, 3'd6}, 1'b0);
    wait_sort(3, 1'b0);
    drain_block({3'd0, 3'd2, 3'd4, 3'd6}, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reverse();
    load_block({3'd7, 3'd6, 3'd5, 3'd4}, 1'b0);
    wait_sort(9, 1'b0);
    drain_block({3'd4, 3'd5, 3'd6, 3'd7}, 1'b0, 1'b0, 5'd6);
  endtask

  task automatic test_duplicates();
    load_block({3'd3, 3'd3, 3'd0, 3'd3}, 1'b0);
    wait_sort(9, 1'b0);
    drain_block({3'd0, 3'd3, 3'd3, 3'd3}, 1'b0, 1'b0, 5'd2);
  endtask

  task automatic test_reset_mid();
    load_block({3'd7, 3'd6, 3'd5, 3'd4}, 1'b0);
    step();
    step();
    step();
    // Now in the 4th SORT cycle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || swap_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b swaps=%0d, want 1 0 0 0",
               in_ready, out_valid, busy, swap_count);
    end
    load_block({3'd2, 3'd1, 3'd0, 3'd3}, 1'b0);
    wait_sort(9, 1'b0);
    drain_block({3'd0, 3'd1, 3'd2, 3'd3}, 1'b0, 1'b0, 5'd3);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 3'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_sorted();
    test_reverse();
    test_duplicates();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
